// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and constants for the Morse symbol decoder
package morse_pkg;

  // Longest legal symbol sequence; one more than this marks overflow.
  localparam int MAX_SYMBOLS = 5;

  // Pattern register width (1 bit per symbol, 1 = dash) and length counter width.
  localparam int PAT_W = 5;
  localparam int LEN_W = 3;

  // Code reported for unknown or over-long sequences.
  localparam logic [7:0] MORSE_ERR_CHAR = 8'h3F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } morse_state_e;

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - combinational (length, pattern, overflow) to ASCII lookup
//
// Ports:
//   length_i    symbols collected (1..MAX_SYMBOLS, MAX_SYMBOLS+1 on overflow)
//   pattern_i   symbols, first symbol in the highest used bit, 1 = dash
//   overflow_i  more than MAX_SYMBOLS symbols were received
//   char_err_o  1 when the sequence has no character
//   char_code_o ASCII code, MORSE_ERR_CHAR when char_err_o is set
//
// Configuration macro: MORSE_DIGITS_EN adds the 5-symbol digit codes '0'..'9'.
module morse_lut
  import morse_pkg::*;
(
  input  logic [LEN_W-1:0] length_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             overflow_i,
  output logic             char_err_o,
  output logic [7:0]       char_code_o
);

  logic       hit;
  logic [7:0] code;

  // Keyed on {length, pattern} so equal bit patterns of different lengths
  // (e.g. 'E' and 'I') stay distinct. Unused high pattern bits are zero.
  always_comb begin
    hit  = 1'b1;
    code = 8'h00;
    case ({length_i, pattern_i})
      {3'd1, 5'b00000}: code = 8'h45; // E .
      {3'd1, 5'b00001}: code = 8'h54; // T -
      {3'd2, 5'b00001}: code = 8'h41; // A .-
      {3'd2, 5'b00000}: code = 8'h49; // I ..
      {3'd2, 5'b00011}: code = 8'h4D; // M --
      {3'd2, 5'b00010}: code = 8'h4E; // N -.
      {3'd3, 5'b00100}: code = 8'h44; // D -..
      {3'd3, 5'b00110}: code = 8'h47; // G --.
      {3'd3, 5'b00101}: code = 8'h4B; // K -.-
      {3'd3, 5'b00111}: code = 8'h4F; // O ---
      {3'd3, 5'b00010}: code = 8'h52; // R .-.
      {3'd3, 5'b00000}: code = 8'h53; // S ...
      {3'd3, 5'b00001}: code = 8'h55; // U ..-
      {3'd3, 5'b00011}: code = 8'h57; // W .--
      {3'd4, 5'b01000}: code = 8'h42; // B -...
      {3'd4, 5'b01010}: code = 8'h43; // C -.-.
      {3'd4, 5'b00010}: code = 8'h46; // F ..-.
      {3'd4, 5'b00000}: code = 8'h48; // H ....
      {3'd4, 5'b00111}: code = 8'h4A; // J .---
      {3'd4, 5'b00100}: code = 8'h4C; // L .-..
      {3'd4, 5'b00110}: code = 8'h50; // P .--.
      {3'd4, 5'b01101}: code = 8'h51; // Q --.-
      {3'd4, 5'b00001}: code = 8'h56; // V ...-
      {3'd4, 5'b01001}: code = 8'h58; // X -..-
      {3'd4, 5'b01011}: code = 8'h59; // Y -.--
      {3'd4, 5'b01100}: code = 8'h5A; // Z --..
`ifdef MORSE_DIGITS_EN
      {3'd5, 5'b11111}: code = 8'h30; // 0 -----
      {3'd5, 5'b01111}: code = 8'h31; // 1 .----
      {3'd5, 5'b00111}: code = 8'h32; // 2 ..---
      {3'd5, 5'b00011}: code = 8'h33; // 3 ...--
      {3'd5, 5'b00001}: code = 8'h34; // 4 ....-
      {3'd5, 5'b00000}: code = 8'h35; // 5 .....
      {3'd5, 5'b10000}: code = 8'h36; // 6 -....
      {3'd5, 5'b11000}: code = 8'h37; // 7 --...
      {3'd5, 5'b11100}: code = 8'h38; // 8 ---..
      {3'd5, 5'b11110}: code = 8'h39; // 9 ----.
`endif
      default: hit = 1'b0;
    endcase

    if (overflow_i || !hit) begin
      char_err_o  = 1'b1;
      char_code_o = MORSE_ERR_CHAR;
    end else begin
      char_err_o  = 1'b0;
      char_code_o = code;
    end
  end

endmodule

// File: rtl/morse_symbol_decoder.sv
// rtl/morse_symbol_decoder.sv - assembles dot/dash symbols into ASCII characters
//
// Ports:
//   clk         system clock (25 MHz)
//   reset       asynchronous active-high reset
//   sym_valid   one-cycle strobe, a classified symbol is present
//   sym_long    1 = dash, 0 = dot; only meaningful with sym_valid
//   char_valid  one-cycle strobe, char_code/char_err valid
//   char_code   ASCII of the decoded character, held until the next char_valid
//   char_err    unknown or too-long sequence (char_code = '?'), held with char_code
//   busy        at least one symbol of the current character is collected
//
// Parameters: TICK_DIV clock cycles per gap tick, GAP_TICKS silent ticks that
// close a character. Configuration macro MORSE_DIGITS_EN (see morse_lut).
module morse_symbol_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = 2604,
  parameter int GAP_TICKS = 14400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic       sym_long,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       char_err,
  output logic       busy
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W   = $clog2(GAP_TICKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_TICKS - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_SYMBOLS);
  localparam logic [LEN_W-1:0]   LEN_OVF    = LEN_W'(MAX_SYMBOLS + 1);

  morse_state_e       state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic               ovf_q, ovf_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               char_valid_q, char_valid_d;
  logic [7:0]         char_code_q, char_code_d;
  logic               char_err_q, char_err_d;
  logic               busy_q, busy_d;

  logic       lut_err;
  logic [7:0] lut_code;

  morse_lut u_lut (
    .length_i    (length_q),
    .pattern_i   (pattern_q),
    .overflow_i  (ovf_q),
    .char_err_o  (lut_err),
    .char_code_o (lut_code)
  );

  // The output registers are loaded on the edge that enters EMIT, so the
  // EMIT cycle is exactly the cycle in which char_valid is high. This gives
  // a latency of GAP_TICKS*TICK_DIV + 1 cycles after the last symbol.
  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    length_d     = length_q;
    ovf_d        = ovf_q;
    presc_d      = presc_q;
    gap_d        = gap_q;
    char_valid_d = 1'b0;
    char_code_d  = char_code_q;
    char_err_d   = char_err_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE, EMIT: begin
        // EMIT also accepts a coincident symbol as the start of the next character.
        pattern_d = '0;
        length_d  = '0;
        ovf_d     = 1'b0;
        presc_d   = '0;
        gap_d     = '0;
        state_d   = IDLE;
        if (sym_valid) begin
          pattern_d = {{(PAT_W-1){1'b0}}, sym_long};
          length_d  = LEN_W'(1);
          busy_d    = 1'b1;
          state_d   = COLLECT;
        end
      end

      COLLECT: begin
        if (sym_valid) begin
          presc_d = '0;
          gap_d   = '0;
          if (length_q < LEN_MAX) begin
            pattern_d = {pattern_q[PAT_W-2:0], sym_long};
            length_d  = length_q + LEN_W'(1);
          end else begin
            // Pattern is frozen once too long; only the flag matters now.
            length_d = LEN_OVF;
            ovf_d    = 1'b1;
          end
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          gap_d   = gap_q + GAP_W'(1);
          if (gap_q == GAP_LAST) begin
            char_valid_d = 1'b1;
            char_code_d  = lut_code;
            char_err_d   = lut_err;
            busy_d       = 1'b0;
            state_d      = EMIT;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pattern_q    <= '0;
      length_q     <= '0;
      ovf_q        <= 1'b0;
      presc_q      <= '0;
      gap_q        <= '0;
      char_valid_q <= 1'b0;
      char_code_q  <= 8'h00;
      char_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      length_q     <= length_d;
      ovf_q        <= ovf_d;
      presc_q      <= presc_d;
      gap_q        <= gap_d;
      char_valid_q <= char_valid_d;
      char_code_q  <= char_code_d;
      char_err_q   <= char_err_d;
      busy_q       <= busy_d;
    end
  end

  assign char_valid = char_valid_q;
  assign char_code  = char_code_q;
  assign char_err   = char_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/morse_symbol_decoder.md
# morse_symbol_decoder

Downstream consumer of the press-duration classifier. It takes one short/long symbol per button release and assembles symbols into a Morse character. It closes the character after a silence timeout and emits the ASCII code as a single-cycle strobe for the display/UART stage. All timing derives from the 25 MHz system clock via an internal tick prescaler, using the same 9600 Hz tick base as the classifier.

## Interface
- TICK_DIV, 2604: clock cycles per gap tick (25 MHz / 9600).
- GAP_TICKS, 14400: ticks of silence that terminate a character (1.5 s).
- MAX_SYMBOLS, 5: longest legal symbol sequence.
- clk  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- sym_valid  in  1  one-cycle strobe: a classified symbol is present.
- sym_long  in  1  qualifies sym_valid: 1 = dash (long press), 0 = dot (short press).
- char_valid  out  1  one-cycle strobe: char_code/char_err valid.
- char_code  out  8  ASCII of decoded character; held until next char_valid.
- char_err  out  1  1 = sequence unknown or too long (char_code = 0x3F '?'); held with char_code.
- busy  out  1  1 while at least one symbol of the current character is collected.

## Operation
- State machine: IDLE, COLLECT, EMIT.
- Pattern register is 5 bits. Each accepted symbol shifts left and enters the LSB (1 = dash).
- Length counter is 3 bits. It saturates at MAX_SYMBOLS+1, which sets the overflow flag.
- IDLE → COLLECT on sym_valid. This stores the first symbol, sets length = 1, and clears the prescaler and gap counter.
- In COLLECT:
  - Each sym_valid appends a symbol, increments length, and clears the prescaler and gap counter.
  - A 6th and later symbol only sets overflow; the pattern is unchanged.
  - Otherwise the prescaler counts 0..TICK_DIV-1. At terminal count it wraps, and the gap counter (width clog2(GAP_TICKS+1)) increments.
  - When the gap counter reaches GAP_TICKS, go to EMIT.
- EMIT (one cycle):
  - Register char_code/char_err from the lookup of (length, pattern), and pulse char_valid.
  - Clear pattern, length and overflow.
  - Return to IDLE.
- Lookup rules:
  - Letters A–Z use lengths 1–4.
  - Any other (length, pattern), or overflow, gives 0x3F with char_err = 1.
- Simultaneous sym_valid in the EMIT cycle: the character still emits. The new symbol is accepted as the first symbol of the next character, and the next state is COLLECT with length = 1.
- sym_long is ignored when sym_valid = 0.

## Timing
- Reset values: char_valid = 0, char_code = 0x00, char_err = 0, busy = 0, state IDLE, all counters 0.
- Latency: if the last sym_valid occurs in cycle T, char_valid is high in cycle T + GAP_TICKS·TICK_DIV + 1, and for exactly one cycle.
- busy rises the cycle after the first sym_valid and falls in the same cycle char_valid rises.
- Reset asserted mid-COLLECT discards the partial character with no char_valid. Outputs return to reset values asynchronously.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- MORSE_DIGITS_EN defined: 5-symbol digit codes decode to '0'–'9' (0x30–0x39), e.g. dot-dash-dash-dash-dash → '1'.
- MORSE_DIGITS_EN undefined: every length-5 sequence decodes as '?' with char_err = 1. The digit LUT entries are not synthesized.

## Structure
- Package morse_pkg holds:
  - the state enum (IDLE/COLLECT/EMIT);
  - the constant MORSE_ERR_CHAR = 8'h3F;
  - MAX_SYMBOLS;
  - the pattern/length widths.
- Sub-module morse_lut is a purely combinational lookup from (length[2:0], pattern[4:0], overflow) to {char_err, char_code[7:0]}. The MORSE_DIGITS_EN guard lives inside it.
- The top level holds the FSM, prescaler, gap counter and output registers.

## Test plan
All scenarios use TICK_DIV = 4 and GAP_TICKS = 3, so latency is 13 cycles after the last symbol.
- Dot at cycle 10, dash at cycle 14 → char_valid at cycle 27, char_code 0x41 'A', char_err 0, busy low at 27.
- Dash, dot, dot, dot, spaced 5 cycles apart → single char_valid, 0x42 'B'.
- Dots spaced 12 cycles apart (just under the gap), three of them → one char 0x53 'S'. At 13-cycle spacing → three separate 'E' (0x45).
- Six dots → 0x3F, char_err 1. Dot-dash-dash-dash-dash → 0x31 with MORSE_DIGITS_EN, 0x3F with char_err 1 without it.
- Two symbols, then reset pulsed before the timeout → no char_valid, outputs 0x00/0/0. A subsequent dot yields 'E' 13 cycles later.
- sym_valid (dot) coincident with the EMIT cycle of 'T' → 'T' (0x54) emitted, then 'E' (0x45) emitted 13 cycles after the coincident symbol.
